// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and defaults for the register-file port arbiter slice.
package regfile_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int X0         = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_grant_arb.sv
// Two-requester arbiter: core has priority, but debug wins once it has been
// passed over STARVE_LIMIT consecutive times.
module regfile_grant_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic core_valid,
    input  logic dbg_valid,
    output logic core_gnt,
    output logic dbg_gnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (en) begin
            if (dbg_valid && (!core_valid || starve_cnt == LIMIT))
                dbg_gnt = 1'b1;
            else if (core_valid)
                core_gnt = 1'b1;
        end
    end

    // A disabled arbiter (drain/halt) forgets any accumulated starvation.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (!en || dbg_gnt || !dbg_valid)
            starve_cnt <= '0;
        else if (core_gnt && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Single-port register-file master shared by the core and debug unit, with a
// RUN -> DRAIN -> HALT sequence granting debug exclusive access.
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [ADDR_W-1:0] core_rs1,
    input  logic [ADDR_W-1:0] core_rs2,
    input  logic [ADDR_W-1:0] core_rd,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_r1,
    output logic [DATA_W-1:0] core_rsp_r2,
    input  logic              dbg_halt,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic              halted,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_dest_val,
    output logic              rf_read_en,
    output logic              rf_write_en,
    input  logic [DATA_W-1:0] rf_r1,
    input  logic [DATA_W-1:0] rf_r2
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(X0);

    arb_state_e        state, state_nxt;
    logic              arb_en, core_gnt, dbg_gnt;
    logic              core_rsp_q, dbg_rsp_q, dbg_we_q;
    logic [DATA_W-1:0] dbg_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // DRAIN and the HALT exit cycle issue nothing, so in-flight reads retire.
    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        case (state)
            ST_RUN: begin
                arb_en = 1'b1;
                if (dbg_halt) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = dbg_halt ? ST_HALT : ST_RUN;
            ST_HALT: begin
                if (dbg_halt) arb_en    = 1'b1;
                else          state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
        if (rst) arb_en = 1'b0;
    end

    regfile_grant_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .core_valid(core_req_valid && state == ST_RUN),
        .dbg_valid (dbg_req_valid),
        .core_gnt  (core_gnt),
        .dbg_gnt   (dbg_gnt)
    );

    assign core_req_ready = core_gnt;
    assign dbg_req_ready  = dbg_gnt;
    assign halted         = (state == ST_HALT);

    always_comb begin
        rf_rs1      = '0;
        rf_rs2      = '0;
        rf_rd       = '0;
        rf_dest_val = '0;
        rf_read_en  = 1'b0;
        rf_write_en = 1'b0;
        if (core_gnt) begin
            rf_rs1      = core_rs1;
            rf_rs2      = core_rs2;
            rf_rd       = core_rd;
            rf_dest_val = core_wdata;
            rf_read_en  = core_rd_en;
            rf_write_en = core_wr_en && (core_rd != ZERO_IDX);
        end else if (dbg_gnt) begin
            rf_rs1      = dbg_addr;
            rf_rd       = dbg_addr;
            rf_dest_val = dbg_wdata;
            rf_read_en  = !dbg_we;
            rf_write_en = dbg_we && (dbg_addr != ZERO_IDX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_rsp_q  <= 1'b0;
            dbg_rsp_q   <= 1'b0;
            dbg_we_q    <= 1'b0;
            dbg_wdata_q <= '0;
        end else begin
            core_rsp_q <= core_gnt && core_rd_en;
            dbg_rsp_q  <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_we_q    <= dbg_we;
                dbg_wdata_q <= dbg_wdata;
            end
        end
    end

    // Responses are masked while rst is held so an in-flight op never surfaces.
    assign core_rsp_valid = core_rsp_q && !rst;
    assign core_rsp_r1    = rf_r1;
    assign core_rsp_r2    = rf_r2;
    assign dbg_rsp_valid  = dbg_rsp_q && !rst;
    assign dbg_rsp_data   = dbg_we_q ? dbg_wdata_q : rf_r1;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts grants and response
// data; a monitor pops expectations as the DUT presents responses.
module tb_regfile_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_valid, core_req_ready;
    logic [4:0]  core_rs1, core_rs2, core_rd;
    logic        core_rd_en, core_wr_en;
    logic [31:0] core_wdata;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_r1, core_rsp_r2;
    logic        dbg_halt, dbg_req_valid, dbg_req_ready;
    logic [4:0]  dbg_addr;
    logic        dbg_we;
    logic [31:0] dbg_wdata;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_data;
    logic        halted;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic [31:0] rf_dest_val;
    logic        rf_read_en, rf_write_en;
    logic [31:0] rf_r1, rf_r2;

    regfile_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd(core_rd),
        .core_rd_en(core_rd_en), .core_wr_en(core_wr_en), .core_wdata(core_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_r1(core_rsp_r1), .core_rsp_r2(core_rsp_r2),
        .dbg_halt(dbg_halt), .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data), .halted(halted),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_dest_val(rf_dest_val),
        .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .rf_r1(rf_r1), .rf_r2(rf_r2)
    );

    always #5 clk = ~clk;

    // Register file: registered read, write visible to the following op.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (rf_write_en) begin
            mem[rf_rd] <= rf_dest_val;
        end
        if (rf_read_en) begin
            rf_r1 <= mem[rf_rs1];
            rf_r2 <= mem[rf_rs2];
        end
    end

    typedef struct packed {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t core_q[$];
    exp_t dbg_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: responses are due exactly one cycle after their issue.
    always @(negedge clk) begin
        exp_t e;
        if (core_q.size() > 0 && core_q[0].cyc == cyc) begin
            e = core_q.pop_front();
            checks++;
            if (rst) begin
                if (core_rsp_valid) begin
                    errors++;
                    $display("FAIL core_rsp_in_reset cyc=%0d valid=%b required 0", cyc, core_rsp_valid);
                end
            end else if (!core_rsp_valid || core_rsp_r1 !== e.a || core_rsp_r2 !== e.b) begin
                errors++;
                $display("FAIL core_rsp cyc=%0d got v=%b r1=%h r2=%h required v=1 r1=%h r2=%h",
                         cyc, core_rsp_valid, core_rsp_r1, core_rsp_r2, e.a, e.b);
            end
        end else if (core_rsp_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL core_rsp_spurious cyc=%0d valid=%b required 0", cyc, core_rsp_valid);
        end
        if (dbg_q.size() > 0 && dbg_q[0].cyc == cyc) begin
            e = dbg_q.pop_front();
            checks++;
            if (rst) begin
                if (dbg_rsp_valid) begin
                    errors++;
                    $display("FAIL dbg_rsp_in_reset cyc=%0d valid=%b required 0", cyc, dbg_rsp_valid);
                end
            end else if (!dbg_rsp_valid || dbg_rsp_data !== e.a) begin
                errors++;
                $display("FAIL dbg_rsp cyc=%0d got v=%b data=%h required v=1 data=%h",
                         cyc, dbg_rsp_valid, dbg_rsp_data, e.a);
            end
        end else if (dbg_rsp_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL dbg_rsp_spurious cyc=%0d valid=%b required 0", cyc, dbg_rsp_valid);
        end
    end

    // Reference model: mode 0 = running, 1 = draining, 2 = halted.
    int          mode = 0;
    int          wins = 0;
    logic [31:0] shadow [32];

    always @(negedge clk) begin
        bit   gc, gd, re, we, exp_halted;
        exp_t e;
        #1;
        gc = 0; gd = 0;
        exp_halted = (mode == 2);
        if (rst) begin
            mode = 0; wins = 0;
            for (int i = 0; i < 32; i++) shadow[i] = '0;
        end else begin
            case (mode)
                0: begin
                    if (core_req_valid && dbg_req_valid) begin
                        if (wins == LIMIT) gd = 1; else gc = 1;
                    end else if (core_req_valid) gc = 1;
                    else if (dbg_req_valid) gd = 1;
                    wins = (gc && dbg_req_valid) ? ((wins < LIMIT) ? wins + 1 : LIMIT) : 0;
                    if (dbg_halt) mode = 1;
                end
                1: begin
                    wins = 0;
                    mode = dbg_halt ? 2 : 0;
                end
                default: begin
                    wins = 0;
                    if (!dbg_halt) mode = 0;
                    else if (dbg_req_valid) gd = 1;
                end
            endcase
        end
        re = gc ? core_rd_en : (gd ? !dbg_we : 1'b0);
        we = gc ? (core_wr_en && core_rd != 0) : (gd ? (dbg_we && dbg_addr != 0) : 1'b0);
        checks++;
        if ({core_req_ready, dbg_req_ready, rf_read_en, rf_write_en, halted} !== {gc, gd, re, we, exp_halted}) begin
            errors++;
            $display("FAIL issue cyc=%0d got crdy=%b drdy=%b re=%b we=%b halted=%b required %b %b %b %b %b",
                     cyc, core_req_ready, dbg_req_ready, rf_read_en, rf_write_en, halted,
                     gc, gd, re, we, exp_halted);
        end
        if (gc && core_rd_en) begin
            e.cyc = cyc + 1; e.a = shadow[core_rs1]; e.b = shadow[core_rs2];
            core_q.push_back(e);
        end
        if (gd) begin
            e.cyc = cyc + 1; e.a = dbg_we ? dbg_wdata : shadow[dbg_addr]; e.b = '0;
            dbg_q.push_back(e);
        end
        if (gc && core_wr_en && core_rd != 0) shadow[core_rd] = core_wdata;
        if (gd && dbg_we && dbg_addr != 0) shadow[dbg_addr] = dbg_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req_valid = 0; core_rd_en = 0; core_wr_en = 0;
        core_rs1 = 0; core_rs2 = 0; core_rd = 0; core_wdata = 0;
        dbg_req_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic core_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic ren, input logic wen, input logic [31:0] wd);
        core_req_valid = 1; core_rs1 = rs1; core_rs2 = rs2; core_rd = rd;
        core_rd_en = ren; core_wr_en = wen; core_wdata = wd;
    endtask

    task automatic dbg_op(input logic [4:0] a, input logic w, input logic [31:0] wd);
        dbg_req_valid = 1; dbg_addr = a; dbg_we = w; dbg_wdata = wd;
    endtask

    function automatic logic [4:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 5'd0;
        if (r == 9) return 5'd31;
        return 5'($urandom_range(1, 7));
    endfunction

    initial begin
        rst = 1; dbg_halt = 0;
        idle();
        tick(); tick(); tick();
        rst = 0;
        tick(); tick();

        // write x5 then read it back with rs2 = x0
        core_op(5'd0, 5'd0, 5'd5, 0, 1, 32'hDEADBEEF); tick();
        core_op(5'd5, 5'd0, 5'd0, 1, 0, 32'h0); tick();
        idle(); tick();

        // x0 stays zero
        core_op(5'd0, 5'd0, 5'd0, 0, 1, 32'h1234); tick();
        core_op(5'd0, 5'd0, 5'd0, 1, 0, 32'h0); tick();
        idle(); tick();

        // both sides held: debug must break through after LIMIT core wins
        core_op(5'd5, 5'd3, 5'd0, 1, 0, 32'h0);
        dbg_op(5'd5, 0, 32'h0);
        repeat (12) tick();
        idle(); tick();

        // halt during a core read, exclusive debug access, then release
        core_op(5'd5, 5'd0, 5'd0, 1, 0, 32'h0);
        dbg_halt = 1; tick();
        tick(); tick();
        dbg_op(5'd31, 1, 32'd7); tick();
        dbg_op(5'd31, 0, 32'd0); tick();
        dbg_req_valid = 0; tick();
        dbg_halt = 0; tick();
        tick(); tick();
        idle(); tick();

        // reset right after a core read is accepted
        core_op(5'd5, 5'd31, 5'd0, 1, 0, 32'h0); tick();
        idle(); rst = 1; tick();
        rst = 0; tick(); tick();

        // debug write echo, then core reads it back
        dbg_op(5'd3, 1, 32'hA5); tick();
        idle(); core_op(5'd3, 5'd0, 5'd0, 1, 0, 32'h0); tick();
        idle(); tick();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) dbg_halt = !dbg_halt;
            core_req_valid = ($urandom_range(0, 3) != 0);
            core_rs1 = pick_addr(); core_rs2 = pick_addr(); core_rd = pick_addr();
            core_rd_en = $urandom_range(0, 1); core_wr_en = $urandom_range(0, 1);
            core_wdata = $urandom;
            dbg_req_valid = ($urandom_range(0, 2) == 0);
            dbg_addr = pick_addr(); dbg_we = $urandom_range(0, 1); dbg_wdata = $urandom;
            tick();
        end

        rst = 0; dbg_halt = 0; idle();
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
